blank_scheduler: RTL

// - Upstream timing stage of blank_mapper in the ISO block. Walks the frame raster and drives

---
 rtl/blank_scheduler_if.sv | 42 ++++
 rtl/blank_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/blank_scheduler_if.sv
// Raster configuration and blanking schedule bundle between blank_scheduler and blank_mapper.
// Optional feature macro: BLANK_SCHED_CLAMP_FLAG_EN adds sched_cfg_clamped.
interface blank_scheduler_if #(
  parameter int CW = 16
);
  logic          cfg_en;
  logic [1:0]    td_lane_count;
  logic [CW-1:0] cfg_h_blank_cyc;
  logic [CW-1:0] cfg_h_active_cyc;
  logic [CW-1:0] cfg_v_blank_lines;
  logic [CW-1:0] cfg_v_active_lines;

  logic          sched_blank_en;
  logic          sched_blank_id;
  logic [1:0]    sched_blank_state;
  logic          sched_active_en;
  logic          sched_line_start;
  logic          sched_frame_start;
`ifdef BLANK_SCHED_CLAMP_FLAG_EN
  logic          sched_cfg_clamped;
`endif

  modport master (
    input  cfg_en, td_lane_count, cfg_h_blank_cyc, cfg_h_active_cyc,
           cfg_v_blank_lines, cfg_v_active_lines,
    output sched_blank_en, sched_blank_id, sched_blank_state, sched_active_en,
           sched_line_start, sched_frame_start
`ifdef BLANK_SCHED_CLAMP_FLAG_EN
    , output sched_cfg_clamped
`endif
  );

  modport slave (
    output cfg_en, td_lane_count, cfg_h_blank_cyc, cfg_h_active_cyc,
           cfg_v_blank_lines, cfg_v_active_lines,
    input  sched_blank_en, sched_blank_id, sched_blank_state, sched_active_en,
           sched_line_start, sched_frame_start
`ifdef BLANK_SCHED_CLAMP_FLAG_EN
    , input sched_cfg_clamped
`endif
  );
endinterface

// File: rtl/blank_scheduler.sv
// Raster walker driving BS/START/BLANK/BE and active-region strobes for blank_mapper.
// Optional feature macro: BLANK_SCHED_CLAMP_FLAG_EN (adds sched_cfg_clamped output).
module blank_scheduler #(
  parameter int CW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  blank_scheduler_if.master  bus
);

  localparam int HW = CW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BS,
    S_START,
    S_BLANK,
    S_BE,
    S_ACTIVE
  } state_t;

  state_t        state_q, state_d;
  // Position counters carry one extra bit so a line of hb+ha cycles (or a frame
  // of vb+va lines) never wraps before its end.
  logic [HW-1:0] h_q, h_d;
  logic [HW-1:0] v_q, v_d;

  // Per-frame configuration snapshot
  logic [CW-1:0] hb_q, ha_q, vb_q, va_q;
  logic [3:0]    s_q;
  logic          clamp_q;

  // ---------------------------------------------------------------------------
  // Live configuration with clamps applied, captured only at frame start
  // ---------------------------------------------------------------------------
  logic [3:0]    s_live;
  logic [CW-1:0] hb_min, hb_live, vb_live;
  logic          hb_clamp_live, vb_clamp_live, load_cfg;

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    s_live = 4'd12;
    case (bus.td_lane_count)
      2'b00:   s_live = 4'd3;
      2'b01:   s_live = 4'd6;
      default: s_live = 4'd12;
    endcase
  end

  assign hb_min        = CW'(s_live) + CW'(9);
  assign hb_clamp_live = bus.cfg_h_blank_cyc < hb_min;
  assign vb_clamp_live = (bus.cfg_v_blank_lines == '0) && (bus.cfg_v_active_lines == '0);
  assign hb_live       = hb_clamp_live ? hb_min : bus.cfg_h_blank_cyc;
  assign vb_live       = vb_clamp_live ? CW'(1) : bus.cfg_v_blank_lines;

  // ---------------------------------------------------------------------------
  // Raster geometry derived from the snapshot
  // ---------------------------------------------------------------------------
  logic [HW-1:0] line_last, frame_last, start_last, blank_last, be_last;
  logic          line_end, frame_end, in_vblank;

  assign line_last  = {1'b0, hb_q} + {1'b0, ha_q} - HW'(1);
  assign frame_last = {1'b0, vb_q} + {1'b0, va_q} - HW'(1);
  assign start_last = HW'(s_q) + HW'(3);
  assign blank_last = {1'b0, hb_q} - HW'(5);
  assign be_last    = {1'b0, hb_q} - HW'(1);
  assign in_vblank  = v_q < {1'b0, vb_q};
  assign line_end   = (state_q != S_IDLE) && (h_q == line_last);
  assign frame_end  = line_end && (v_q == frame_last);
  assign load_cfg   = bus.cfg_en && ((state_q == S_IDLE) || frame_end);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q <= S_IDLE;
      h_q     <= '0;
      v_q     <= '0;
      hb_q    <= '0;
      ha_q    <= '0;
      vb_q    <= '0;
      va_q    <= '0;
      s_q     <= '0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      if (load_cfg) begin
        hb_q    <= hb_live;
        ha_q    <= bus.cfg_h_active_cyc;
        vb_q    <= vb_live;
        va_q    <= bus.cfg_v_active_lines;
        s_q     <= s_live;
        clamp_q <= hb_clamp_live || vb_clamp_live;
      end else if (!bus.cfg_en) begin
        clamp_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    if (!bus.cfg_en) begin
      state_d = S_IDLE;
      h_d     = '0;
      v_d     = '0;
    end else if (state_q == S_IDLE) begin
      state_d = S_BS;
      h_d     = '0;
      v_d     = '0;
    end else if (line_end) begin
      // Every line, V-blank or active, opens with BS; a zero-length active
      // region falls through here straight from BE.
      state_d = S_BS;
      h_d     = '0;
      v_d     = frame_end ? '0 : v_q + HW'(1);
    end else begin
      h_d = h_q + HW'(1);
      case (state_q)
        S_BS:     if (h_q == HW'(3))   state_d = S_START;
        S_START:  if (h_q == start_last) state_d = S_BLANK;
        S_BLANK:  if (!in_vblank && h_q == blank_last) state_d = S_BE;
        S_BE:     if (h_q == be_last)  state_d = S_ACTIVE;
        default:  state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode, registered one cycle behind the position it describes
  // ---------------------------------------------------------------------------
  logic       blank_en_d, blank_id_d, active_en_d, line_start_d, frame_start_d;
  logic [1:0] blank_state_d;
  logic       running;

  assign running = bus.cfg_en && (state_q != S_IDLE);

  always_comb begin
    blank_state_d = 2'b00;
    case (state_q)
      S_BS:    blank_state_d = 2'b01;
      S_START: blank_state_d = 2'b10;
      S_BE:    blank_state_d = 2'b11;
      default: blank_state_d = 2'b00;
    endcase
    blank_en_d    = running && (state_q != S_ACTIVE);
    blank_id_d    = blank_en_d && !in_vblank;
    active_en_d   = running && (state_q == S_ACTIVE);
    line_start_d  = running && (h_q == '0);
    frame_start_d = line_start_d && (v_q == '0);
    if (!blank_en_d) blank_state_d = 2'b00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sched_blank_en    <= 1'b0;
      bus.sched_blank_id    <= 1'b0;
      bus.sched_blank_state <= 2'b00;
      bus.sched_active_en   <= 1'b0;
      bus.sched_line_start  <= 1'b0;
      bus.sched_frame_start <= 1'b0;
    end else begin
      bus.sched_blank_en    <= blank_en_d;
      bus.sched_blank_id    <= blank_id_d;
      bus.sched_blank_state <= blank_state_d;
      bus.sched_active_en   <= active_en_d;
      bus.sched_line_start  <= line_start_d;
      bus.sched_frame_start <= frame_start_d;
    end
  end

`ifdef BLANK_SCHED_CLAMP_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.sched_cfg_clamped <= 1'b0;
    else        bus.sched_cfg_clamped <= running && clamp_q;
  end
`endif

endmodule
